// File: rtl/shift_add_mult_ctrl_if.sv
// Bundle of the front-end (operands/start/result) and external-adder
// signals of the shift-and-add multiplier controller.
//   master : the surroundings (switches/buttons, display, ripple adder)
//   slave  : the controller itself
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  modport master (
    output start, mcand, mplier, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );

  modport slave (
    input  start, mcand, mplier, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add WIDTH x WIDTH unsigned multiplier controller.
// Drives an external ripple-carry adder one partial product at a time and
// holds its operands for SETTLE cycles before sampling sum/carry.
// Optional macro MULT_ZERO_SKIP_EN: bits with Q[0]=0 bypass the ADD state,
// giving a data-dependent latency.
module shift_add_mult_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_mult_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam int BW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     m_q;        // multiplicand
  logic [WIDTH-1:0]     a_q;        // accumulator (high product half)
  logic [WIDTH-1:0]     q_q;        // multiplier, becomes low product half
  logic                 c_q;        // carry out of the last add
  logic [BW-1:0]        bit_cnt_q;
  logic [SW-1:0]        set_cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     add_a_q;
  logic [WIDTH-1:0]     add_b_q;

  // Control FSM with datapath and registered outputs; adder operands are
  // loaded on entry to ADD and cleared on exit, so they come from flops only.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the shift below relies on reading the old a_q/c_q/q_q together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      bit_cnt_q <= '0;
      set_cnt_q <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            m_q       <= bus.mcand;
            q_q       <= bus.mplier;
            a_q       <= '0;
            c_q       <= 1'b0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_TEST;
          end
        end

        S_TEST: begin
          set_cnt_q <= '0;
`ifdef MULT_ZERO_SKIP_EN
          if (!q_q[0]) begin
            state_q <= S_SHIFT;
          end else begin
            add_a_q <= a_q;
            add_b_q <= m_q;
            state_q <= S_ADD;
          end
`else
          add_a_q <= a_q;
          add_b_q <= q_q[0] ? m_q : '0;
          state_q <= S_ADD;
`endif
        end

        S_ADD: begin
          if (set_cnt_q == SET_LAST) begin
            {c_q, a_q} <= {bus.add_cout, bus.add_sum};
            add_a_q    <= '0;
            add_b_q    <= '0;
            state_q    <= S_SHIFT;
          end else begin
            set_cnt_q  <= set_cnt_q + 1'b1;
          end
        end

        S_SHIFT: begin
          c_q <= 1'b0;
          a_q <= {c_q, a_q[WIDTH-1:1]};
          q_q <= {a_q[0], q_q[WIDTH-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            // Capture the shifted {A,Q} now so product is valid during DONE.
            product_q <= {c_q, a_q, q_q[WIDTH-1:1]};
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= S_TEST;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.add_a   = add_a_q;
  assign bus.add_b   = add_b_q;
  assign bus.add_cin = 1'b0;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: two instances (SETTLE=8 and
// SETTLE=1) share stimulus; each has a behavioural ripple adder attached.
// Expected latencies depend on MULT_ZERO_SKIP_EN.
module tb_shift_add_mult_ctrl;

  localparam int W  = 4;
  localparam int S0 = 8;

`ifdef MULT_ZERO_SKIP_EN
  localparam int L_FF = 41;
  localparam int L_65 = 25;
  localparam int L_90 = 9;
  localparam int L_0B = 33;
  localparam int L_37 = 33;
`else
  localparam int L_FF = 41;
  localparam int L_65 = 41;
  localparam int L_90 = 41;
  localparam int L_0B = 41;
  localparam int L_37 = 41;
`endif

  typedef struct {
    int         lat;
    int         done_cnt;
    int         busy_cnt;
    int         busy_after;
    int         busy_after2;
    int         runs;
    int         bad_runs;
    int         cin_bad;
    logic [7:0] prod;
  } op_res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_add_mult_ctrl_if #(.WIDTH(W)) if0 ();
  shift_add_mult_ctrl_if #(.WIDTH(W)) if1 ();

  shift_add_mult_ctrl #(.WIDTH(W), .SETTLE(S0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  shift_add_mult_ctrl #(.WIDTH(W), .SETTLE(1))  dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // External adders
  assign {if0.add_cout, if0.add_sum} = 5'(if0.add_a) + 5'(if0.add_b) + 5'(if0.add_cin);
  assign {if1.add_cout, if1.add_sum} = 5'(if1.add_a) + 5'(if1.add_b) + 5'(if1.add_cin);

  // Second instance follows the same front-end stimulus
  assign if1.start  = if0.start;
  assign if1.mcand  = if0.mcand;
  assign if1.mplier = if0.mplier;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE and observe it cycle by cycle.
  // Cycle n is sampled 1 time unit after the n-th edge, the accept edge being 1.
  task automatic run_op(input logic [3:0] mc, input logic [3:0] mp,
                        input int pulse_at, input bit hold,
                        input logic [3:0] mc2, input logic [3:0] mp2,
                        output op_res_t r);
    logic [7:0] prev;
    logic [7:0] cur;
    int         run_len;
    r = '{default: 0};
    prev = '0;
    run_len = 0;
    if0.mcand  = mc;
    if0.mplier = mp;
    if0.start  = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1 && !hold) if0.start = 1'b0;
      cur = {if0.add_a, if0.add_b};
      if (cur != prev && prev != 0 && run_len != S0) r.bad_runs++;
      if (cur != 0) begin
        if (cur != prev) begin
          r.runs++;
          run_len = 1;
        end else begin
          run_len++;
        end
      end
      prev = cur;
      if (if0.add_cin !== 1'b0) r.cin_bad++;
      if (r.lat == 0 && if0.busy === 1'b1) r.busy_cnt++;
      if (if0.done === 1'b1) begin
        r.done_cnt++;
        if (r.lat == 0) begin
          r.lat  = cyc;
          r.prod = if0.product;
        end
      end
      if (pulse_at != 0 && cyc == pulse_at) begin
        if0.start  = 1'b1;
        if0.mcand  = mc2;
        if0.mplier = mp2;
      end
      if (pulse_at != 0 && cyc == pulse_at + 1) if0.start = 1'b0;
      if (hold && r.lat != 0 && cyc == r.lat) begin
        if0.mcand  = mc2;
        if0.mplier = mp2;
      end
      if (r.lat != 0 && cyc == r.lat + 1) r.busy_after = int'(if0.busy);
      if (r.lat != 0 && cyc == r.lat + 2) begin
        r.busy_after2 = int'(if0.busy);
        break;
      end
    end
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      #1;
      if (if0.done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input op_res_t r, input int exp_lat, input logic [7:0] exp_prod);
    check({tag, "_lat"},      64'(r.lat),        64'(exp_lat));
    check({tag, "_prod"},     64'(r.prod),       64'(exp_prod));
    check({tag, "_done1"},    64'(r.done_cnt),   64'd1);
    check({tag, "_busycnt"},  64'(r.busy_cnt),   64'(exp_lat));
    check({tag, "_idle"},     64'(r.busy_after), 64'd0);
    check({tag, "_hold"},     64'(r.bad_runs),   64'd0);
    check({tag, "_cin"},      64'(r.cin_bad),    64'd0);
  endtask

  op_res_t res;
  bit      found;

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    if0.start  = 1'b0;
    if0.mcand  = '0;
    if0.mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    64'(if0.busy),    64'd0);
    check("rst_done",    64'(if0.done),    64'd0);
    check("rst_product", 64'(if0.product), 64'd0);
    check("rst_add_a",   64'(if0.add_a),   64'd0);
    check("rst_add_b",   64'(if0.add_b),   64'd0);
    check("rst_add_cin", 64'(if0.add_cin), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // 15 x 15: every bit adds, four operand holds of SETTLE cycles each
    run_op(4'd15, 4'd15, 0, 1'b0, 4'd0, 4'd0, res);
    check_op("ff", res, L_FF, 8'hE1);
    check("ff_runs",      64'(res.runs),        64'd4);
    check("ff_stay_idle", 64'(res.busy_after2), 64'd0);
    check("settle1_prod", 64'(if1.product),     64'd225);

    // 6 x 5 = 30
    run_op(4'd6, 4'd5, 0, 1'b0, 4'd0, 4'd0, res);
    check_op("m65", res, L_65, 8'd30);

    // Zero multiplier and zero multiplicand
    run_op(4'd9, 4'd0, 0, 1'b0, 4'd0, 4'd0, res);
    check_op("m90", res, L_90, 8'd0);
    run_op(4'd0, 4'd11, 0, 1'b0, 4'd0, 4'd0, res);
    check_op("m0b", res, L_0B, 8'd0);

    // start pulse with new operands at cycle 10 is ignored
    run_op(4'd15, 4'd15, 10, 1'b0, 4'd2, 4'd3, res);
    check_op("busy_start", res, L_FF, 8'hE1);
    check("busy_start_noqueue", 64'(res.busy_after2), 64'd0);

    // start held high: next op accepted one idle cycle after done
    run_op(4'd6, 4'd5, 0, 1'b1, 4'd3, 4'd4, res);
    check_op("held", res, L_65, 8'd30);
    check("held_restart", 64'(res.busy_after2), 64'd1);
    if0.start = 1'b0;
    wait_done(found);
    check("held_second_done", 64'(found),       64'd1);
    check("held_second_prod", 64'(if0.product), 64'd12);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of 9 x 9
    if0.mcand  = 4'd9;
    if0.mplier = 4'd9;
    if0.start  = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid_busy_before", 64'(if0.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",    64'(if0.busy),    64'd0);
    check("mid_rst_done",    64'(if0.done),    64'd0);
    check("mid_rst_product", 64'(if0.product), 64'd0);
    check("mid_rst_add_b",   64'(if0.add_b),   64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(4'd3, 4'd7, 0, 1'b0, 4'd0, 4'd0, res);
    check_op("m37", res, L_37, 8'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential controller that computes a WIDTH x WIDTH unsigned product by driving an external WIDTH-bit ripple-carry adder (bitadder) one partial product at a time, using shift-and-add.
- Holds the adder inputs stable for SETTLE clock cycles before sampling, so gate-delay ripple completes at the board clock (50 MHz on the Spartan-3E kit).
- Sits between the switch/button front end (operands, start) and the LED/7-seg display (product).

Parameters:
- WIDTH, 4, operand width in bits; must equal the external adder width.
- SETTLE, 8, cycles each adder operand set is held before sum/carry are sampled; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request multiply; sampled only in IDLE
- mcand  input  WIDTH  multiplicand; captured when start is accepted
- mplier  input  WIDTH  multiplier; captured when start is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, high in DONE
- product  output  2*WIDTH  result; valid from DONE until the next accepted start
- add_a  output  WIDTH  adder operand a (to in_1)
- add_b  output  WIDTH  adder operand b (to in_2)
- add_cin  output  1  adder carry-in (to C0); constant 0
- add_sum  input  WIDTH  adder sum (from sol)
- add_cout  input  1  adder carry-out (from C4)

Behaviour:
- Reset (async, rst=1): state=IDLE. Registers M, A, Q, C, bit_cnt, set_cnt and product are all cleared. busy=0, done=0, add_a=add_b=0, add_cin=0. Reset mid-operation aborts the operation with no partial result.
- Registers:
  - M: multiplicand, WIDTH.
  - A: accumulator, WIDTH.
  - Q: multiplier/low product, WIDTH.
  - C: carry, 1 bit.
  - bit_cnt: 0..WIDTH-1.
  - set_cnt: 0..SETTLE-1.
- IDLE: if start=1, load M=mcand, Q=mplier, A=0, C=0, bit_cnt=0, then go to TEST. Otherwise stay in IDLE.
- TEST (1 cycle): set set_cnt=0 and go to ADD. The MULT_ZERO_SKIP_EN macro modifies this state (see Optional Feature).
- ADD:
  - add_a=A; add_b=M if Q[0]=1, else 0.
  - Both are decoded from registers only; there is no combinational path from any input port.
  - set_cnt increments each cycle.
  - On the cycle where set_cnt==SETTLE-1: {C,A} <= {add_cout,add_sum}, then go to SHIFT.
  - Outside ADD, add_a=add_b=0.
- SHIFT (1 cycle):
  - {C,A,Q} <= {1'b0,C,A,Q} >> 1, i.e. C <= 0, A <= {C,A[W-1:1]}, Q <= {A[0],Q[W-1:1]}.
  - If bit_cnt==WIDTH-1, go to DONE; otherwise increment bit_cnt and go to TEST.
- DONE (1 cycle): product <= {A,Q}, done=1, busy=1, then go to IDLE. product holds its value until the next accepted start.
- start while busy=1 is ignored, with no queuing. start held high continuously gives back-to-back operations with 1 IDLE cycle between them.
- Arithmetic: unsigned only; a 2*WIDTH result cannot overflow. The carry out of each add is preserved through C into the shift.
- Latency: done is high N cycles after the clk edge that accepts start.
  - Without MULT_ZERO_SKIP_EN: N = 2*WIDTH + WIDTH*SETTLE + 1. With defaults, N = 41 for all operands.
  - With MULT_ZERO_SKIP_EN: N = 2*WIDTH + k*SETTLE + 1, where k = popcount(mplier).

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: in TEST, if Q[0]=0, go directly to SHIFT and skip ADD; the adder is untouched, and A and C are unchanged. If Q[0]=1, go to ADD. Latency becomes data-dependent (see Behaviour).
- Undefined: every bit passes through ADD, with add_b=0 when Q[0]=0. Latency is constant.

Test Plan:
- Defaults, macro off: start with mcand=15, mplier=15 -> product=8'hE1 (225); done is a single pulse at cycle 41; busy is high for cycles 1..41.
- Macro off: mcand=6, mplier=5 -> product=30, done at 41. Macro on, same operands -> product=30, done at 25.
- Zero operands: mcand=9, mplier=0 -> product=0 (done at 9 with macro on, 41 with macro off). mcand=0, mplier=11 -> product=0.
- Adder hold check: during every ADD, add_a/add_b stay constant for exactly SETTLE cycles and add_cin=0. With SETTLE=1 and mcand=15, mplier=15, the product is still 225.
- Start during busy: pulse start with new operands at cycle 10 of an operation -> ignored; the original product is delivered. Start held high -> second operation is accepted 1 cycle after done.
- Reset mid-operation: assert rst at cycle 20 -> busy=0, done=0 and product=0 immediately (asynchronously). After release, a fresh 3*7 -> product=21.
